// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Purpose  : Shares the read and write ports of the 4096x32 instruction ROM.
//            Read port:  instruction fetch vs. load/store loads.
//            Write port: preflash loader vs. load/store stores.
//            Returns one-cycle-latency read data to the requester that issued
//            the read. Bypasses same-cycle write data to a colliding read.
//            Guarantees fetch forward progress with a starvation counter.
// Ports    : clk, rst (async active-low)
//            if_*  : fetch read request / grant / response
//            ls_*  : load/store request / grant / response
//            ld_*  : loader write request / grant
//            rom_* : ROM read and write port drive, rom_r_data_i response
//            busy_o: loader active or read response pending
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    output logic        ld_gnt_o,

    output logic        rom_w_en_o,
    output logic [31:0] rom_w_addr_o,
    output logic [31:0] rom_w_data_o,
    output logic        rom_r_en_o,
    output logic [31:0] rom_r_addr_o,
    input  logic [31:0] rom_r_data_i,

    output logic        busy_o
);

    // Response owner encoding
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_IF   = 2'd1;
    localparam logic [1:0] c_OWN_LS   = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0]  rd_own_q, rd_own_d;
    logic [3:0]  starve_q, starve_d;
    logic        byp_q,    byp_d;
    logic [31:0] byp_data_q, byp_data_d;

    logic        w_ls_load;
    logic        w_ls_store;
    logic        w_rd_allow;
    logic        w_if_gnt;
    logic        w_ls_rd_gnt;
    logic        w_ls_wr_gnt;
    logic        w_ld_gnt;
    logic        w_collide;
    logic [31:0] w_rdata;

    // ------------------------------------------------------------------------
    // Arbitration. Every grant is qualified with rst so that all outputs are
    // held at 0 while reset is asserted, even with requests pending.
    // ------------------------------------------------------------------------
    assign w_ls_load  = ls_req_i & ~ls_we_i;
    assign w_ls_store = ls_req_i &  ls_we_i;

    // The loader owns the ROM exclusively for reads while it is active.
    assign w_rd_allow = rst & ~ld_req_i;

    assign w_if_gnt    = w_rd_allow & if_req_i &
                         (~w_ls_load | (starve_q == c_STARVE_MAX));
    assign w_ls_rd_gnt = w_rd_allow & w_ls_load & ~w_if_gnt;
    assign w_ld_gnt    = rst & ld_req_i;
    assign w_ls_wr_gnt = rst & w_ls_store & ~ld_req_i;

    assign if_gnt_o = w_if_gnt;
    assign ls_gnt_o = w_ls_rd_gnt | w_ls_wr_gnt;
    assign ld_gnt_o = w_ld_gnt;

    // ------------------------------------------------------------------------
    // ROM port drive: ungranted ports present all-zero address/data.
    // ------------------------------------------------------------------------
    always_comb begin
        rom_r_en_o   = w_if_gnt | w_ls_rd_gnt;
        rom_r_addr_o = 32'd0;
        if (w_if_gnt) begin
            rom_r_addr_o = if_addr_i;
        end else if (w_ls_rd_gnt) begin
            rom_r_addr_o = ls_addr_i;
        end
    end

    always_comb begin
        rom_w_en_o   = w_ld_gnt | w_ls_wr_gnt;
        rom_w_addr_o = 32'd0;
        rom_w_data_o = 32'd0;
        if (w_ld_gnt) begin
            rom_w_addr_o = ld_addr_i;
            rom_w_data_o = ld_wdata_i;
        end else if (w_ls_wr_gnt) begin
            rom_w_addr_o = ls_addr_i;
            rom_w_data_o = ls_wdata_i;
        end
    end

    // Only the word index reaches the ROM, so only it matters for a collision.
    assign w_collide = rom_r_en_o & rom_w_en_o &
                       (rom_r_addr_o[13:2] == rom_w_addr_o[13:2]);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        rd_own_d = c_OWN_NONE;
        if (w_if_gnt) begin
            rd_own_d = c_OWN_IF;
        end else if (w_ls_rd_gnt) begin
            rd_own_d = c_OWN_LS;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (if_req_i && !w_if_gnt) begin
            starve_d = (starve_q == c_STARVE_MAX) ? c_STARVE_MAX
                                                  : starve_q + 4'd1;
        end
    end

    // The ROM returns the pre-write word on a collision, so the written word
    // is captured here and substituted on the response cycle.
    assign byp_d      = w_collide;
    assign byp_data_d = w_collide ? rom_w_data_o : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_own_q   <= c_OWN_NONE;
            starve_q   <= 4'd0;
            byp_q      <= 1'b0;
            byp_data_q <= 32'd0;
        end else begin
            rd_own_q   <= rd_own_d;
            starve_q   <= starve_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------------
    assign w_rdata     = byp_q ? byp_data_q : rom_r_data_i;
    assign if_rvalid_o = (rd_own_q == c_OWN_IF);
    assign ls_rvalid_o = (rd_own_q == c_OWN_LS);

    // Data is forced to zero when no response is pending so the outputs are
    // quiet in reset and between responses.
    assign if_rdata_o = (rd_own_q != c_OWN_NONE) ? w_rdata : 32'd0;
    assign ls_rdata_o = (rd_own_q != c_OWN_NONE) ? w_rdata : 32'd0;

    assign busy_o = rst & (ld_req_i | (rd_own_q != c_OWN_NONE));

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_arbiter
// Purpose  : Directed self-checking bench for rom_arbiter with a behavioural
//            4096x32 ROM (registered read, read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i, ls_req_i, ls_we_i, ld_req_i;
    logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, ld_addr_i, ld_wdata_i;
    logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, ld_gnt_o;
    logic [31:0] if_rdata_o, ls_rdata_o;
    logic        rom_w_en_o, rom_r_en_o, busy_o;
    logic [31:0] rom_w_addr_o, rom_w_data_o, rom_r_addr_o, rom_r_data_i;

    int n_tests;
    int n_fail;

    logic [31:0] mem [0:4095];

    rom_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_gnt_o     (ls_gnt_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .ls_rdata_o   (ls_rdata_o),
        .ld_req_i     (ld_req_i),
        .ld_addr_i    (ld_addr_i),
        .ld_wdata_i   (ld_wdata_i),
        .ld_gnt_o     (ld_gnt_o),
        .rom_w_en_o   (rom_w_en_o),
        .rom_w_addr_o (rom_w_addr_o),
        .rom_w_data_o (rom_w_data_o),
        .rom_r_en_o   (rom_r_en_o),
        .rom_r_addr_o (rom_r_addr_o),
        .rom_r_data_i (rom_r_data_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered read returns the old word on a same-cycle write.
    always @(posedge clk) begin
        if (rom_w_en_o) mem[rom_w_addr_o[13:2]] <= rom_w_data_o;
        if (rom_r_en_o) rom_r_data_i <= mem[rom_r_addr_o[13:2]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 0; ls_req_i = 0; ls_we_i = 0; ld_req_i = 0;
        if_addr_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
        ld_addr_i = 0; ld_wdata_i = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | 32'(i);
        rom_r_data_i = 32'd0;
        idle_inputs();
        rst = 1'b0;

        // ---------------- Reset with every request high ----------------
        repeat (2) @(posedge clk);
        #1;
        if_req_i = 1; if_addr_i = 32'h10;
        ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h20;
        ld_req_i = 1; ld_addr_i = 32'h30; ld_wdata_i = 32'h1234_5678;
        @(negedge clk);
        check("rst_if_gnt",   {31'd0, if_gnt_o},    0);
        check("rst_ls_gnt",   {31'd0, ls_gnt_o},    0);
        check("rst_ld_gnt",   {31'd0, ld_gnt_o},    0);
        check("rst_rvalid",   {30'd0, if_rvalid_o, ls_rvalid_o}, 0);
        check("rst_rom_en",   {30'd0, rom_r_en_o, rom_w_en_o},   0);
        check("rst_rom_addr", rom_r_addr_o | rom_w_addr_o | rom_w_data_o, 0);
        check("rst_rdata",    if_rdata_o | ls_rdata_o, 0);
        check("rst_busy",     {31'd0, busy_o},      0);

        // ---------------- Release: fetch 0x10 ----------------
        next_cycle();
        rst = 1'b1;
        ls_req_i = 0; ld_req_i = 0;
        @(negedge clk);
        check("rel_if_gnt",   {31'd0, if_gnt_o}, 1);
        check("rel_r_addr",   rom_r_addr_o, 32'h10);
        next_cycle();
        if_req_i = 0;
        @(negedge clk);
        check("rel_if_rvalid", {31'd0, if_rvalid_o}, 1);
        check("rel_ls_rvalid", {31'd0, ls_rvalid_o}, 0);
        check("rel_if_rdata",  if_rdata_o, 32'hA500_0004);

        // ---------------- Fetch-only stream 0x0,0x4,0x8 ----------------
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if_req_i  = (k < 3);
            if_addr_i = (k < 3) ? 32'(4 * k) : 32'd0;
            @(negedge clk);
            if (k < 3) check("fs_if_gnt", {31'd0, if_gnt_o}, 1);
            if (k > 0) begin
                check("fs_if_rvalid", {31'd0, if_rvalid_o}, 1);
                check("fs_if_rdata",  if_rdata_o, 32'hA500_0000 + 32'(k - 1));
                check("fs_ls_rvalid", {31'd0, ls_rvalid_o}, 0);
            end
        end

        // ---------------- Contention: LS x4 then IF ----------------
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            if_req_i = 1; if_addr_i = 32'h20;
            ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h30;
            @(negedge clk);
            check("ct_if_gnt", {31'd0, if_gnt_o}, (k % 5 == 4) ? 32'd1 : 32'd0);
            check("ct_ls_gnt", {31'd0, ls_gnt_o}, (k % 5 == 4) ? 32'd0 : 32'd1);
            if (k > 0) begin
                check("ct_if_rvalid", {31'd0, if_rvalid_o},
                      ((k - 1) % 5 == 4) ? 32'd1 : 32'd0);
                check("ct_ls_rvalid", {31'd0, ls_rvalid_o},
                      ((k - 1) % 5 == 4) ? 32'd0 : 32'd1);
                check("ct_rdata", if_rdata_o,
                      ((k - 1) % 5 == 4) ? 32'hA500_0008 : 32'hA500_000C);
            end
        end
        next_cycle();
        idle_inputs();

        // ---------------- Collision bypass ----------------
        next_cycle();
        if_req_i = 1; if_addr_i = 32'h40;
        ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h40; ls_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("col_if_gnt", {31'd0, if_gnt_o}, 1);
        check("col_ls_gnt", {31'd0, ls_gnt_o}, 1);
        check("col_w_data", rom_w_data_o, 32'hDEAD_BEEF);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("col_if_rvalid", {31'd0, if_rvalid_o}, 1);
        check("col_if_rdata",  if_rdata_o, 32'hDEAD_BEEF);
        next_cycle();
        if_req_i = 1; if_addr_i = 32'h40;
        next_cycle();
        if_req_i = 0;
        @(negedge clk);
        check("col_reread", if_rdata_o, 32'hDEAD_BEEF);

        // ---------------- Loader priority ----------------
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ld_req_i = 1; ld_addr_i = 32'h80; ld_wdata_i = 32'h1111_2222;
            ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h84; ls_wdata_i = 32'h3333_4444;
            if_req_i = 1; if_addr_i = 32'h0;
            @(negedge clk);
            check("ldp_ld_gnt", {31'd0, ld_gnt_o}, 1);
            check("ldp_ls_gnt", {31'd0, ls_gnt_o}, 0);
            check("ldp_if_gnt", {31'd0, if_gnt_o}, 0);
            check("ldp_busy",   {31'd0, busy_o},   1);
            check("ldp_w_addr", rom_w_addr_o, 32'h80);
        end
        next_cycle();
        ld_req_i = 0;
        @(negedge clk);
        check("ldp_store_gnt", {31'd0, ls_gnt_o}, 1);
        check("ldp_store_adr", rom_w_addr_o, 32'h84);
        check("ldp_if_after",  {31'd0, if_gnt_o}, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("ldp_if_rvalid", {31'd0, if_rvalid_o}, 1);

        // ---------------- Reset during outstanding load ----------------
        next_cycle();
        ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h8;
        @(negedge clk);
        check("mr_ls_gnt", {31'd0, ls_gnt_o}, 1);
        rst = 1'b0;
        #1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            if (k == 1) rst = 1'b1;
            @(negedge clk);
            check("mr_ls_rvalid", {31'd0, ls_rvalid_o}, 0);
            check("mr_if_rvalid", {31'd0, if_rvalid_o}, 0);
            check("mr_busy",      {31'd0, busy_o},      0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_arbiter.md
# rom_arbiter

Arbiter in front of the 4096×32 instruction ROM, which has a single registered read port and a single write port. It shares the read port between the instruction-fetch unit and the load/store unit, and the write port between the preflash loader and load/store stores. It routes the one-cycle-latency read data back to the requester that issued the read. It also bypasses same-cycle write data to a colliding read, and guarantees fetch forward progress with a starvation counter.

## Interface
- STARVE_MAX, 4: consecutive denied fetch cycles after which fetch wins the read port (range 1–15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch read accepted this cycle (combinational)
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store (write), 0 = load (read)
- ls_addr_i  in  32  load/store byte address
- ls_wdata_i  in  32  store data
- ls_gnt_o  out  1  load/store request accepted this cycle (combinational)
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  32  load data
- ld_req_i  in  1  loader write request
- ld_addr_i  in  32  loader byte address
- ld_wdata_i  in  32  loader write data
- ld_gnt_o  out  1  loader write accepted (combinational)
- rom_w_en_o  out  1  ROM write enable
- rom_w_addr_o  out  32  ROM write byte address
- rom_w_data_o  out  32  ROM write data
- rom_r_en_o  out  1  ROM read enable
- rom_r_addr_o  out  32  ROM read byte address
- rom_r_data_i  in  32  ROM read data, valid the cycle after rom_r_en_o
- busy_o  out  1  ld_req_i is high or a read response is pending

## Operation
- Read port candidates: fetch (if_req_i) and load (ls_req_i & !ls_we_i). Write port candidates: loader (ld_req_i) and store (ls_req_i & ls_we_i).
- Read arbitration:
  - The load wins by default.
  - Fetch wins if it is the only read requester, or if starve_cnt == STARVE_MAX.
  - While ld_req_i is high, no reads are granted.
- Write arbitration:
  - The loader always wins.
  - A store is granted only when ld_req_i is low.
  - Reads and writes may be granted in the same cycle.
- The granted request drives the rom_* address and data outputs. When a port is not granted, its enable is 0 and its address and data are 0.
- starve_cnt (4-bit):
  - Increments, saturating at STARVE_MAX, when if_req_i=1 and if_gnt_o=0.
  - Clears when if_gnt_o=1 or if_req_i=0.
- Response owner register rd_own ∈ {NONE, IF, LS} is loaded each cycle with the read granted this cycle (NONE if no read was granted).
- Next cycle, the response is routed by rd_own:
  - rd_own=IF: if_rvalid_o=1.
  - rd_own=LS: ls_rvalid_o=1.
  - The other rvalid is 0.
  - Both rdata outputs carry the returned word.
- Collision bypass:
  - If a read and a write are granted in the same cycle and rom_r_addr_o[13:2] == rom_w_addr_o[13:2], the arbiter registers the write data and a bypass flag.
  - The next cycle's rdata is the registered write data instead of rom_r_data_i.
- Address bits [31:14] and [1:0] are passed through unmodified. The ROM wrapper ignores them, and they are not used in the collision compare.

## Timing
- Grants are combinational, in the same cycle as the request. A request not granted must be held by the requester.
- Read latency is 1 cycle: the grant in cycle N gives rvalid in cycle N+1. Back-to-back reads sustain 1 read per cycle.
- Write latency is 0 at the interface: the grant cycle is the ROM write cycle.
- Reset (rst=0, asynchronous):
  - rd_own=NONE, starve_cnt=0, bypass flag=0.
  - All outputs are 0.
  - Any pending response is dropped; no rvalid is issued after reset release for a read granted before reset.
- Reset release: the first grant is possible in the first cycle with rst=1.
- Loader assert while a read is outstanding: the outstanding rvalid is still delivered the next cycle. Only new read grants are blocked.
- Starvation: with ls load and fetch both requesting every cycle, loads are granted for STARVE_MAX cycles, then fetch for one cycle, and the pattern repeats.

## Test plan
- Reset: hold rst=0 with all requests high -> all grants and rvalids are 0 and all rom_* outputs are 0. Release -> fetch at 0x0000_0010 granted; next cycle if_rvalid_o=1 with the ROM word at index 4.
- Fetch-only stream at addresses 0x0, 0x4, 0x8 -> grants every cycle, rvalid on 3 consecutive cycles, data in order, ls_rvalid_o stays 0.
- Contention with STARVE_MAX=4, fetch and load both requesting continuously -> grant pattern LS,LS,LS,LS,IF repeating. if_rvalid_o appears every 5th cycle.
- Collision: store 0xDEADBEEF to 0x40 while fetch reads 0x40 in the same cycle -> next cycle if_rdata_o=0xDEADBEEF. A later fetch of 0x40 also returns 0xDEADBEEF.
- Loader priority: ld_req_i and a store both high for 3 cycles -> ld_gnt_o=1 and ls_gnt_o=0 for all 3 cycles, no read grants, and busy_o=1. The store is granted in the cycle after ld_req_i falls.
- Reset mid-read: grant a load in cycle N, assert rst=0 in cycle N+1 -> ls_rvalid_o is never asserted for that load, and rd_own=NONE after release.
